pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline; sits beside the forwarding unit.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state type and defaults for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2,
        HALT  = 2'd3
    } pctrl_state_t;

    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       Rs1D_i,
    input  logic [4:0]       Rs2D_i,
    input  logic [4:0]       RdE_i,
    input  logic             LoadE_i,
    input  logic             PCSrcE_i,
    input  logic             ImemReady_i,
    input  logic             DmemReqM_i,
    input  logic             DmemReadyM_i,
    input  logic             HaltW_i,
    input  logic             resume_i,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             StallW_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    pctrl_state_t state;
    logic         dmiss;
    logic         imiss;
    logic         lu;
    logic         freeze;
    logic         flush_br;

    always_comb begin
        dmiss    = DmemReqM_i & ~DmemReadyM_i;
        imiss    = ~ImemReady_i;
        lu       = LoadE_i & (RdE_i != 5'd0) & ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));
        // DWAIT keeps the whole pipe frozen through the ready cycle so M captures on the next edge
        freeze   = (state == HALT) | (state == DWAIT) | HaltW_i | dmiss;
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        StallW_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        flush_br = 1'b0;
        halted_o = 1'b0;
        if (rst_ni) begin
            halted_o = (state == HALT);
            if (freeze) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                StallW_o = 1'b1;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
                flush_br = 1'b1;
            end else if (lu || imiss) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (HaltW_i)                          state <= HALT;
                    else if (dmiss)                       state <= DWAIT;
                    else if (imiss && !PCSrcE_i && !lu)   state <= IWAIT;
                end
                DWAIT: begin
                    if (DmemReadyM_i) state <= RUN;
                end
                IWAIT: begin
                    // E/M/W keep moving while fetch waits, so a halt or data miss can still arrive
                    if (HaltW_i)          state <= HALT;
                    else if (dmiss)       state <= DWAIT;
                    else if (ImemReady_i) state <= RUN;
                end
                HALT: begin
                    if (resume_i) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (StallF_o),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (flush_br),
        .cnt_o  (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       load, pcsrc, imem_ready, dmem_req, dmem_ready, halt_w, resume;
    logic       sf, sd, se, sm, sw, fd, fe, halted;
    logic [3:0] stall_cnt, flush_cnt;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outs = {sf, sd, se, sm, sw, fd, fe, halted};

    pipeline_ctrl #(.CNT_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .Rs1D_i       (rs1),
        .Rs2D_i       (rs2),
        .RdE_i        (rd),
        .LoadE_i      (load),
        .PCSrcE_i     (pcsrc),
        .ImemReady_i  (imem_ready),
        .DmemReqM_i   (dmem_req),
        .DmemReadyM_i (dmem_ready),
        .HaltW_i      (halt_w),
        .resume_i     (resume),
        .StallF_o     (sf),
        .StallD_o     (sd),
        .StallE_o     (se),
        .StallM_o     (sm),
        .StallW_o     (sw),
        .FlushD_o     (fd),
        .FlushE_o     (fe),
        .halted_o     (halted),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        load = 1'b0; rd = 5'd0; rs1 = 5'd1; rs2 = 5'd2;
        pcsrc = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
        halt_w = 1'b0; resume = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // outs = {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,halted}
    initial begin
        idle();
        rst_n = 1'b0;
        load = 1'b1; rd = 5'd5; rs1 = 5'd5;
        @(negedge clk);
        check("rst_outs", 32'(outs), 32'h00);
        check("rst_scnt", 32'(stall_cnt), 32'd0);
        check("rst_fcnt", 32'(flush_cnt), 32'd0);
        next();
        rst_n = 1'b1;

        // load-use on rs1
        idle(); load = 1'b1; rd = 5'd5; rs1 = 5'd5;
        @(negedge clk); check("lu", 32'(outs), 32'hC2);
        next(); idle();
        @(negedge clk); check("lu_clear", 32'(outs), 32'h00);
        check("lu_scnt", 32'(stall_cnt), 32'd1);

        // x0 destination is never a hazard; branch overrides load-use
        next(); load = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        @(negedge clk); check("lu_x0", 32'(outs), 32'h00);
        next(); load = 1'b1; rd = 5'd7; rs2 = 5'd7; pcsrc = 1'b1;
        @(negedge clk); check("br_lu", 32'(outs), 32'h06);
        next(); idle();
        @(negedge clk); check("br_fcnt", 32'(flush_cnt), 32'd1);
        check("br_scnt", 32'(stall_cnt), 32'd1);

        // data miss: 3 wait cycles plus the ready cycle, branch held frozen meanwhile
        for (int i = 0; i < 3; i++) begin
            next(); dmem_req = 1'b1; dmem_ready = 1'b0; pcsrc = (i == 1);
            @(negedge clk); check("dmiss", 32'(outs), 32'hF8);
        end
        next(); pcsrc = 1'b0; dmem_ready = 1'b1;
        @(negedge clk); check("dwait_rdy", 32'(outs), 32'hF8);
        next(); idle();
        @(negedge clk); check("dwait_done", 32'(outs), 32'h00);
        check("dwait_scnt", 32'(stall_cnt), 32'd5);
        check("dwait_fcnt", 32'(flush_cnt), 32'd1);

        // instruction miss: W keeps writing back
        for (int i = 0; i < 2; i++) begin
            next(); imem_ready = 1'b0;
            @(negedge clk); check("imiss", 32'(outs), 32'hC2);
        end
        next(); imem_ready = 1'b1;
        @(negedge clk); check("iwait_rdy", 32'(outs), 32'h00);
        next(); idle();
        @(negedge clk); check("iwait_scnt", 32'(stall_cnt), 32'd7);

        // halt: held 10 cycles, stall counter saturates at 15
        next(); halt_w = 1'b1;
        @(negedge clk); check("halt_entry", 32'(outs), 32'hF8);
        for (int i = 1; i <= 10; i++) begin
            next();
            @(negedge clk); check("halt_hold", 32'(outs), 32'hF9);
            check("halt_scnt", 32'(stall_cnt), (7 + i > 15) ? 32'd15 : 32'(7 + i));
        end
        next(); resume = 1'b1;
        @(negedge clk); check("resume_cyc", 32'(outs), 32'hF9);
        next(); idle();
        @(negedge clk); check("resumed", 32'(outs), 32'h00);
        check("sat_scnt", 32'(stall_cnt), 32'd15);
        check("sat_fcnt", 32'(flush_cnt), 32'd1);

        // halt and data miss in the same cycle: halt wins
        next(); halt_w = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); check("hd_entry", 32'(outs), 32'hF8);
        next(); halt_w = 1'b0;
        @(negedge clk); check("hd_halted", 32'(outs), 32'hF9);
        next(); resume = 1'b1; dmem_ready = 1'b1;
        @(negedge clk); check("hd_resume", 32'(outs), 32'hF9);
        next(); resume = 1'b0;
        @(negedge clk); check("hd_run", 32'(outs), 32'h00);

        // asynchronous reset while in DWAIT
        next(); idle(); dmem_req = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); check("rd_dmiss", 32'(outs), 32'hF8);
        next();
        rst_n = 1'b0;
        #1;
        check("rd_outs", 32'(outs), 32'h00);
        check("rd_scnt", 32'(stall_cnt), 32'd0);
        check("rd_fcnt", 32'(flush_cnt), 32'd0);
        next();
        rst_n = 1'b1; dmem_ready = 1'b1;
        @(negedge clk); check("rd_run", 32'(outs), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
